lock_sequencer: RTL and testbench
=================================

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter DEFAULT_CODE, 16'h1234, code loaded at reset (four 4-bit digits, MSB digit first).
REQ-002 Parameter OPEN_CYCLES, 8, clock cycles unlock stays asserted after a correct entry.
REQ-003 Parameter MAX_FAIL, 3, consecutive failed entries that trigger lockout.
REQ-004 Parameter LOCK_CYCLES, 16, clock cycles of lockout.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-high.
REQ-007 key_valid  input  1  one-cycle strobe: key_digit valid.
REQ-008 key_digit  input  4  entered digit.
REQ-009 enter  input  1  one-cycle strobe: submit entry.
REQ-010 set_mode  input  1  one-cycle strobe: request code change (honoured only in OPEN).
REQ-011 unlock  output  1  lock open.
REQ-012 fail  output  1  one-cycle pulse per rejected entry.
REQ-013 locked  output  1  lockout active; all inputs ignored.
REQ-014 code_updated  output  1  one-cycle pulse when a new code is stored.
REQ-015 digit_cnt  output  3  digits captured in the current entry, 0..4.
REQ-016 fail_cnt  output  3  consecutive failures, saturating at 7.

Function
REQ-017 States IDLE, ENTRY, CHECK, OPEN, SET, LOCKED; all outputs registered.
REQ-018 IDLE/ENTRY: each key_valid shifts key_digit into a 16-bit entry buffer (left shift, new digit in [3:0]) and increments digit_cnt; IDLE->ENTRY on first digit.
REQ-019 key_valid when digit_cnt==4: digit dropped, digit_cnt stays 4.
REQ-020 enter in IDLE/ENTRY -> CHECK next cycle; key_valid in the same cycle as enter is dropped (enter has priority).
REQ-021 CHECK (exactly one cycle): match requires digit_cnt==4 and buffer==stored code.
REQ-022 Match -> OPEN: unlock=1 from the next cycle for exactly OPEN_CYCLES cycles, fail_cnt cleared, then IDLE.
REQ-023 Mismatch -> fail=1 for one cycle, fail_cnt+1 (saturating), then IDLE, or LOCKED per REQ-027.
REQ-024 Leaving CHECK or SET clears the entry buffer and digit_cnt.
REQ-025 set_mode in OPEN -> SET: unlock drops next cycle; digits captured as in REQ-018; enter with digit_cnt==4 writes the buffer to the stored code, code_updated=1 one cycle, -> IDLE; enter with digit_cnt<4 discards the buffer, code unchanged, -> IDLE, no fail pulse.
REQ-026 set_mode outside OPEN is ignored; key_valid/enter in OPEN are ignored.

Reset
REQ-028 clr asserted at any time, including mid-entry, OPEN or LOCKED: state IDLE, stored code=DEFAULT_CODE, buffer=0, digit_cnt=0, fail_cnt=0, unlock=fail=locked=code_updated=0.
REQ-029 First input sampled on the first rising edge after clr deasserts.

Configuration
REQ-027 With LOCKOUT_EN defined: a failure that brings fail_cnt to MAX_FAIL enters LOCKED; locked=1 for exactly LOCK_CYCLES cycles, all inputs ignored; exit clears fail_cnt, goes to IDLE.
REQ-030 Without LOCKOUT_EN: LOCKED state absent, locked tied 0, fail_cnt still counts and saturates as a diagnostic.

Structure
REQ-031 Shared package lock_pkg holds the state enum, DIGITS=4, DIGIT_W=4, CODE_W=16.
REQ-032 One sub-module lock_timer (load value, decrement, done flag), reused for OPEN and LOCKED durations.

Verification (DEFAULT_CODE=16'h1234, OPEN_CYCLES=8, MAX_FAIL=3, LOCK_CYCLES=16)
REQ-033 Keys 1,2,3,4 then enter -> unlock high 8 cycles starting 2 cycles after enter, fail_cnt=0.
REQ-034 Keys 1,2,3,5 then enter, three times -> fail pulses, fail_cnt 1,2,3; with LOCKOUT_EN, locked=1 for 16 cycles, keys 1,2,3,4+enter during lockout -> no unlock; afterwards fail_cnt=0.
REQ-035 Keys 1,2,3 then enter -> fail pulse; keys 1,2,3,4,9 then enter -> unlock (fifth digit dropped).
REQ-036 Open, set_mode, keys 9,8,7,6, enter -> code_updated pulse; 1,2,3,4+enter -> fail; 9,8,7,6+enter -> unlock.
REQ-037 key_valid and enter in the same cycle after 1,2,3,4 -> digit dropped, unlock.
REQ-038 clr mid-OPEN after code changed to 16'h9876 -> unlock=0 at once; 1,2,3,4+enter -> unlock.

Source files
------------

// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_pkg
//  Description : Shared types and sizes for the keypad lock sequencer:
//                digit/code geometry, counter width, FSM state encoding and
//                a saturating increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lock_pkg;

    localparam int DIGITS  = 4;                 // digits per code
    localparam int DIGIT_W = 4;                 // bits per digit
    localparam int CODE_W  = DIGITS * DIGIT_W;  // 16-bit code
    localparam int CNT_W   = 3;                 // digit_cnt / fail_cnt width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_OPEN   = 3'd3,
        ST_SET    = 3'd4,
        ST_LOCKED = 3'd5
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage : lock_pkg
`default_nettype wire

// File: rtl/lock_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lock_sequencer_if
//  Description : Keypad / status bundle of the lock sequencer.
//                master : keypad side (drives strobes, reads status)
//                slave  : lock_sequencer side
//  Signals     : key_valid, key_digit[3:0], enter, set_mode  (keypad -> lock)
//                unlock, fail, locked, code_updated,
//                digit_cnt[2:0], fail_cnt[2:0]              (lock -> keypad)
//  Revision    : 1.0  initial release
// ============================================================================
interface lock_sequencer_if;
    import lock_pkg::*;

    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               enter;
    logic               set_mode;

    logic               unlock;
    logic               fail;
    logic               locked;
    logic               code_updated;
    logic [CNT_W-1:0]   digit_cnt;
    logic [CNT_W-1:0]   fail_cnt;

    modport master (
        output key_valid, key_digit, enter, set_mode,
        input  unlock, fail, locked, code_updated, digit_cnt, fail_cnt
    );

    modport slave (
        input  key_valid, key_digit, enter, set_mode,
        output unlock, fail, locked, code_updated, digit_cnt, fail_cnt
    );

endinterface : lock_sequencer_if
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lock_timer
//  Description : Loadable down-counter with a terminal flag. Shared by the
//                OPEN and LOCKED dwell periods of the lock sequencer.
//                Loading N-1 yields a flag on the Nth enabled cycle.
//  Ports       : clk        clock, rising edge
//                clr        asynchronous active-high reset
//                i_load     load i_load_val (wins over decrement)
//                i_load_val value to load
//                i_en       decrement while non-zero
//                o_done     counter has reached zero
//  Revision    : 1.0  initial release
// ============================================================================
module lock_timer #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         clr,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_load_val,
    input  wire logic         i_en,
    output logic              o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule : lock_timer
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lock_sequencer
//  Description : Four-digit keypad lock. Digits are shifted into an entry
//                buffer; enter compares against the stored code. A match
//                opens the lock for OPEN_CYCLES cycles, during which set_mode
//                allows a new code to be programmed. Mismatches pulse fail
//                and are counted (saturating at 7).
//  Config      : LOCKOUT_EN - when defined, MAX_FAIL consecutive failures
//                enter a LOCK_CYCLES lockout with all inputs ignored.
//                Otherwise locked is tied low.
//  Ports       : clk   clock, rising edge
//                clr   asynchronous active-high reset
//                bus   lock_sequencer_if.slave (keypad strobes and status)
//  Revision    : 1.0  initial release
// ============================================================================
module lock_sequencer
    import lock_pkg::*;
#(
    parameter logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int                OPEN_CYCLES  = 8,
    parameter int                MAX_FAIL     = 3,
    parameter int                LOCK_CYCLES  = 16
) (
    input  wire logic          clk,
    input  wire logic          clr,
    lock_sequencer_if.slave    bus
);

`ifdef LOCKOUT_EN
    localparam bit c_LOCKOUT = 1'b1;
`else
    localparam bit c_LOCKOUT = 1'b0;
`endif

    localparam int c_TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    state_t            r_state;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] r_buf;
    logic [CNT_W-1:0]  r_digit_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;
    logic              r_unlock;
    logic              r_fail;
    logic              r_code_updated;
`ifdef LOCKOUT_EN
    logic              r_locked;
`endif

    logic               w_full;
    logic               w_match;
    logic [CNT_W-1:0]   w_fail_nxt;
    logic               w_lock_trip;
    logic               w_tmr_load;
    logic [c_TMR_W-1:0] w_tmr_val;
    logic               w_tmr_en;
    logic               w_tmr_done;

    assign w_full      = (r_digit_cnt == CNT_W'(DIGITS));
    assign w_match     = w_full && (r_buf == r_code);
    assign w_fail_nxt  = sat_inc(r_fail_cnt);
    assign w_lock_trip = c_LOCKOUT && (w_fail_nxt == CNT_W'(MAX_FAIL));

    // The timer is (re)loaded during the single CHECK cycle with whichever
    // dwell follows; it then counts in OPEN or LOCKED.
    assign w_tmr_load = (r_state == ST_CHECK);
    assign w_tmr_val  = w_match ? c_TMR_W'(OPEN_CYCLES - 1) : c_TMR_W'(LOCK_CYCLES - 1);
    assign w_tmr_en   = (r_state == ST_OPEN) || (r_state == ST_LOCKED);

    lock_timer #(
        .W (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .clr        (clr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state        <= ST_IDLE;
            r_code         <= DEFAULT_CODE;
            r_buf          <= '0;
            r_digit_cnt    <= '0;
            r_fail_cnt     <= '0;
            r_unlock       <= 1'b0;
            r_fail         <= 1'b0;
            r_code_updated <= 1'b0;
`ifdef LOCKOUT_EN
            r_locked       <= 1'b0;
`endif
        end else begin
            r_fail         <= 1'b0;
            r_code_updated <= 1'b0;

            case (r_state)
                ST_IDLE, ST_ENTRY: begin
                    // enter outranks a coincident key_valid
                    if (bus.enter) begin
                        r_state <= ST_CHECK;
                    end else if (bus.key_valid && !w_full) begin
                        r_buf       <= {r_buf[CODE_W-DIGIT_W-1:0], bus.key_digit};
                        r_digit_cnt <= r_digit_cnt + CNT_W'(1);
                        r_state     <= ST_ENTRY;
                    end
                end

                ST_CHECK: begin
                    r_buf       <= '0;
                    r_digit_cnt <= '0;
                    if (w_match) begin
                        r_state    <= ST_OPEN;
                        r_unlock   <= 1'b1;
                        r_fail_cnt <= '0;
                    end else begin
                        r_fail     <= 1'b1;
                        r_fail_cnt <= w_fail_nxt;
                        if (w_lock_trip) begin
                            r_state <= ST_LOCKED;
`ifdef LOCKOUT_EN
                            r_locked <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_OPEN: begin
                    // A code-change request takes precedence over expiry.
                    if (bus.set_mode) begin
                        r_state  <= ST_SET;
                        r_unlock <= 1'b0;
                    end else if (w_tmr_done) begin
                        r_state  <= ST_IDLE;
                        r_unlock <= 1'b0;
                    end
                end

                ST_SET: begin
                    if (bus.enter) begin
                        // A short entry is silently abandoned.
                        if (w_full) begin
                            r_code         <= r_buf;
                            r_code_updated <= 1'b1;
                        end
                        r_buf       <= '0;
                        r_digit_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else if (bus.key_valid && !w_full) begin
                        r_buf       <= {r_buf[CODE_W-DIGIT_W-1:0], bus.key_digit};
                        r_digit_cnt <= r_digit_cnt + CNT_W'(1);
                    end
                end

`ifdef LOCKOUT_EN
                ST_LOCKED: begin
                    if (w_tmr_done) begin
                        r_state    <= ST_IDLE;
                        r_locked   <= 1'b0;
                        r_fail_cnt <= '0;
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.unlock       = r_unlock;
    assign bus.fail         = r_fail;
    assign bus.code_updated = r_code_updated;
    assign bus.digit_cnt    = r_digit_cnt;
    assign bus.fail_cnt     = r_fail_cnt;
`ifdef LOCKOUT_EN
    assign bus.locked       = r_locked;
`else
    assign bus.locked       = 1'b0;
`endif

endmodule : lock_sequencer
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_sequencer
//  Description : Directed self-checking bench for lock_sequencer with
//                DEFAULT_CODE=16'h1234, OPEN_CYCLES=8, MAX_FAIL=3,
//                LOCK_CYCLES=16. Lockout checks follow LOCKOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lock_sequencer;
    import lock_pkg::*;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    lock_sequencer_if bus ();

    lock_sequencer #(
        .DEFAULT_CODE (16'h1234),
        .OPEN_CYCLES  (8),
        .MAX_FAIL     (3),
        .LOCK_CYCLES  (16)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        step();
        bus.key_valid = 1'b0;
        bus.key_digit = 4'h0;
    endtask

    task automatic code4(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    endtask

    // Strobe enter, then land in the cycle where the CHECK result shows.
    task automatic enter_and_settle();
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
    endtask

    int ones;
    int lk;
    int saw;

    initial begin
        bus.key_valid = 1'b0;
        bus.key_digit = 4'h0;
        bus.enter     = 1'b0;
        bus.set_mode  = 1'b0;
        clr           = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_unlock",   32'(bus.unlock),       0);
        chk("rst_fail",     32'(bus.fail),         0);
        chk("rst_locked",   32'(bus.locked),       0);
        chk("rst_code_upd", 32'(bus.code_updated), 0);
        chk("rst_digit",    32'(bus.digit_cnt),    0);
        chk("rst_failcnt",  32'(bus.fail_cnt),     0);
        clr = 1'b0;

        // Correct code: unlock 2 cycles after enter, for 8 cycles
        code4(16'h1234);
        chk("digits_4", 32'(bus.digit_cnt), 4);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("unlock_in_check", 32'(bus.unlock), 0);
        step();
        chk("unlock_rise",   32'(bus.unlock),   1);
        chk("open_failcnt0", 32'(bus.fail_cnt), 0);
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.unlock) ones++;
            step();
        end
        chk("open_len",   32'(ones),       8);
        chk("open_ended", 32'(bus.unlock), 0);

        // Short entry fails; fifth digit dropped
        press(4'd1); press(4'd2); press(4'd3);
        enter_and_settle();
        chk("short_fail",    32'(bus.fail),     1);
        chk("short_failcnt", 32'(bus.fail_cnt), 1);
        chk("short_nounlk",  32'(bus.unlock),   0);
        step();
        chk("fail_one_cyc",  32'(bus.fail),     0);
        code4(16'h1234);
        press(4'd9);
        chk("digit_cap_4",   32'(bus.digit_cnt), 4);
        enter_and_settle();
        chk("fifth_dropped", 32'(bus.unlock),   1);
        chk("match_clr_cnt", 32'(bus.fail_cnt), 0);
        repeat (10) step();

        // key_valid coincident with enter is dropped
        code4(16'h1234);
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd5;
        bus.enter     = 1'b1;
        step();
        bus.key_valid = 1'b0;
        bus.key_digit = 4'h0;
        bus.enter     = 1'b0;
        step();
        chk("enter_priority", 32'(bus.unlock), 1);
        repeat (10) step();

        // Code change to 9876
        code4(16'h1234);
        enter_and_settle();
        bus.set_mode = 1'b1;
        step();
        bus.set_mode = 1'b0;
        chk("set_unlock_drop", 32'(bus.unlock), 0);
        code4(16'h9876);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        chk("code_upd_pulse", 32'(bus.code_updated), 1);
        step();
        chk("code_upd_1cyc",  32'(bus.code_updated), 0);
        code4(16'h1234);
        enter_and_settle();
        chk("old_code_fail",  32'(bus.fail),   1);
        step();
        code4(16'h9876);
        enter_and_settle();
        chk("new_code_open",  32'(bus.unlock), 1);

        // Short set entry discarded; set_mode outside OPEN ignored
        bus.set_mode = 1'b1;
        step();
        bus.set_mode = 1'b0;
        press(4'd1);
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
        chk("short_set_noupd",  32'(bus.code_updated), 0);
        chk("short_set_nofail", 32'(bus.fail),         0);
        bus.set_mode = 1'b1;
        step();
        bus.set_mode = 1'b0;
        code4(16'h9876);
        enter_and_settle();
        chk("code_kept_open", 32'(bus.unlock), 1);

        // Asynchronous clear mid-OPEN restores the default code
        step(); step();
        clr = 1'b1;
        #1;
        chk("clr_async_unlock", 32'(bus.unlock), 0);
        step();
        clr = 1'b0;
        code4(16'h1234);
        enter_and_settle();
        chk("clr_default_code", 32'(bus.unlock), 1);
        repeat (10) step();

        // Three consecutive failures
        for (int k = 1; k <= 3; k++) begin
            code4(16'h1235);
            enter_and_settle();
            chk("bad_fail",    32'(bus.fail),     1);
            chk("bad_failcnt", 32'(bus.fail_cnt), k);
            if (k < 3) step();
        end
`ifdef LOCKOUT_EN
        lk  = 0;
        saw = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.locked) lk++;
            if (bus.unlock) saw++;
            bus.key_valid = (i < 4);
            bus.key_digit = 4'(i + 1);
            bus.enter     = (i == 4);
            step();
        end
        bus.key_valid = 1'b0;
        bus.key_digit = 4'h0;
        bus.enter     = 1'b0;
        chk("lock_len",       32'(lk),            16);
        chk("lock_no_unlock", 32'(saw),           0);
        chk("lock_exit_cnt",  32'(bus.fail_cnt),  0);
        chk("lock_ignored",   32'(bus.digit_cnt), 0);
`else
        chk("no_lockout", 32'(bus.locked), 0);
        step();
        for (int k = 0; k < 5; k++) begin
            code4(16'h1235);
            enter_and_settle();
            step();
        end
        chk("failcnt_sat", 32'(bus.fail_cnt), 7);
`endif
        code4(16'h1234);
        enter_and_settle();
        chk("final_open",    32'(bus.unlock),   1);
        chk("final_failcnt", 32'(bus.fail_cnt), 0);
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lock_sequencer
`default_nettype wire
